// File: rtl/scan_sequencer_pkg.sv
// Shared types and helpers for the scan sequencer: FSM state encoding and
// the sizing rule for the shared blank/dwell interval timer.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DWELL = 2'd2
    } scan_state_t;

    // One down-counter serves both intervals, so it must hold the longer one.
    function automatic int timer_width(input int dwell, input int blank);
        int longest;
        longest = (dwell > blank) ? dwell : blank;
        if (longest < 1) begin
            return 1;
        end
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/scan_sequencer_if.sv
// Control/status bundle between a scan controller (master) and the
// sequencer (slave) that drives the decoder select and enable.
interface scan_sequencer_if #(
    parameter int IDX_BITS = 4
);
    logic                start;
    logic                stop;
    logic                one_shot;
    logic [IDX_BITS-1:0] last_idx;
    logic [IDX_BITS-1:0] idx;
    logic                en;
    logic                busy;
    logic                step;
    logic                frame_done;

    modport master (
        output start, stop, one_shot, last_idx,
        input  idx, en, busy, step, frame_done
    );

    modport slave (
        input  start, stop, one_shot, last_idx,
        output idx, en, busy, step, frame_done
    );
endinterface

// File: rtl/scan_sequencer_timer.sv
// Loadable down-counter used for both blank and dwell intervals.
// A load of N-1 gives exactly N cycles, the last of which shows expired.
// expire_next is the value expired will take after the coming edge, so the
// sequencer can register pulses that must line up with the final cycle.
module scan_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired,
    output logic         expire_next
);
    logic [W-1:0] count_q;

    // Count down to zero and park there until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign expired     = (count_q == '0);
    assign expire_next = load ? (load_val == '0) : (count_q <= W'(1));
endmodule

// File: rtl/scan_sequencer.sv
// Scan sequencer: walks the decoder select from 0 to a programmable last
// index, holding the enable high for a dwell interval per step with an
// optional blanking gap before each step. Continuous or one-shot frames.
// All outputs come straight from flops.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int IDX_BITS     = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input logic            clk,
    input logic            rst_n,
    scan_sequencer_if.slave bus
);
    localparam int TMR_W = timer_width(DWELL_CYCLES, BLANK_CYCLES);

    // Each step opens with a blank interval unless blanking is disabled,
    // in which case it opens directly with the dwell interval.
    localparam scan_state_t     STEP_STATE = (BLANK_CYCLES == 0) ? DWELL : BLANK;
    localparam int              STEP_LEN   = (BLANK_CYCLES == 0) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam logic [TMR_W-1:0] STEP_LOAD  = TMR_W'(STEP_LEN - 1);
    localparam logic [TMR_W-1:0] DWELL_LOAD = TMR_W'(DWELL_CYCLES - 1);

    scan_state_t         state_q, state_nxt;
    logic [IDX_BITS-1:0] idx_q, idx_nxt;
    logic [IDX_BITS-1:0] last_q, last_nxt;
    logic                os_q, os_nxt;

    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_load_val;
    logic                tmr_expired;
    logic                tmr_expire_next;

    logic                en_q, busy_q, step_q, frame_done_q;
    logic                en_d, busy_d, step_d, frame_done_d;
    logic                at_last;

    scan_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (tmr_load),
        .load_val    (tmr_load_val),
        .expired     (tmr_expired),
        .expire_next (tmr_expire_next)
    );

    // Comparing against the latched last index (rather than incrementing
    // blindly) keeps idx from ever wrapping, even when last is all ones.
    assign at_last = (idx_q == last_q);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state, index, frame-parameter and timer-load decisions.
    always_comb begin
        state_nxt    = state_q;
        idx_nxt      = idx_q;
        last_nxt     = last_q;
        os_nxt       = os_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        unique case (state_q)
            IDLE: begin
                // stop wins over a simultaneous start
                if (bus.start && !bus.stop) begin
                    os_nxt       = bus.one_shot;
                    last_nxt     = bus.last_idx;
                    idx_nxt      = '0;
                    state_nxt    = STEP_STATE;
                    tmr_load     = 1'b1;
                    tmr_load_val = STEP_LOAD;
                end
            end

            BLANK: begin
                if (bus.stop) begin
                    state_nxt = IDLE;
                end else if (tmr_expired) begin
                    state_nxt    = DWELL;
                    tmr_load     = 1'b1;
                    tmr_load_val = DWELL_LOAD;
                end
            end

            DWELL: begin
                if (bus.stop) begin
                    state_nxt = IDLE;
                end else if (tmr_expired) begin
                    if (at_last && os_q) begin
                        // one-shot frame complete; idx keeps the last value
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt      = at_last ? '0 : idx_q + IDX_BITS'(1);
                        state_nxt    = STEP_STATE;
                        tmr_load     = 1'b1;
                        tmr_load_val = STEP_LOAD;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Index and latched frame parameters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            last_q <= '0;
            os_q   <= 1'b0;
        end else begin
            idx_q  <= idx_nxt;
            last_q <= last_nxt;
            os_q   <= os_nxt;
        end
    end

    // Output decode from the next state, so the flops line up with it.
    // A new step begins on any entry into DWELL from elsewhere, or when a
    // dwell expires straight into another dwell (no blanking).
    always_comb begin
        en_d         = (state_nxt == DWELL);
        busy_d       = (state_nxt != IDLE);
        step_d       = (state_nxt == DWELL) && ((state_q != DWELL) || tmr_expired);
        frame_done_d = (state_nxt == DWELL) && tmr_expire_next && (idx_nxt == last_nxt);
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q         <= 1'b0;
            busy_q       <= 1'b0;
            step_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            en_q         <= en_d;
            busy_q       <= busy_d;
            step_q       <= step_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.idx        = idx_q;
    assign bus.en         = en_q;
    assign bus.busy       = busy_q;
    assign bus.step       = step_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Upstream driver for the 4-to-16 binary decoder: produces the select index (`idx`) and enable (`en`) that feed the decoder's `in`/`en` inputs.
- Steps `idx` from 0 to a programmable last index.
- Holds `en` high for a fixed dwell time per step, with a blanking gap (`en` low) between steps to prevent ghosting on multiplexed LED/display strobes.
- Supports free-running (continuous) and one-shot frame modes.

Parameters:
- IDX_BITS, 4, width of `idx`; decoder fan-out is 2**IDX_BITS.
- DWELL_CYCLES, 1000, clock cycles `en` stays high per step; legal range >= 1.
- BLANK_CYCLES, 2, clock cycles `en` stays low before each step; legal range >= 0 (0 = no blanking).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a frame when idle.
- stop  input  1  single-cycle pulse; aborts scanning.
- one_shot  input  1  mode, sampled on an accepted start: 1 = single frame, 0 = repeat frames.
- last_idx  input  IDX_BITS  final index of a frame, sampled on an accepted start.
- idx  output  IDX_BITS  decoder select.
- en  output  1  decoder enable.
- busy  output  1  high in any state other than IDLE.
- step  output  1  one-cycle pulse on the cycle `en` rises.
- frame_done  output  1  one-cycle pulse on the last dwell cycle of `last_idx`.

Behaviour:
- Reset (async assert, sync release): state IDLE; `idx` = 0; `en` = 0; `busy` = 0; `step` = 0; `frame_done` = 0; latched mode/last cleared.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, BLANK, DWELL.
- IDLE:
  - `start` = 1 and `stop` = 0: latch `one_shot` and `last_idx`; `idx` <= 0; go to BLANK, or to DWELL if BLANK_CYCLES = 0.
  - Otherwise stay in IDLE. `stop` wins over a simultaneous `start`.
- BLANK:
  - `en` = 0 for exactly BLANK_CYCLES cycles, then go to DWELL.
  - `step` pulses on the first DWELL cycle.
- DWELL:
  - `en` = 1 for exactly DWELL_CYCLES cycles; `idx` stable throughout.
  - On the final dwell cycle:
    - If `idx` != latched last: `idx` <= `idx` + 1; go to BLANK/DWELL.
    - If `idx` == latched last: pulse `frame_done`, then:
      - one-shot: go to IDLE; `idx` holds its value.
      - continuous: `idx` <= 0; wrap to BLANK/DWELL.
- `idx` changes only while `en` = 0, except when BLANK_CYCLES = 0, where it changes on the same edge the new step begins.
- `stop` in BLANK or DWELL:
  - Next cycle: state IDLE, `en` = 0, `idx` holds its value, no `frame_done`.
- `start` while busy is ignored; mode and last are not re-sampled.
- `last_idx` = 0 is legal: single-step frames.
- `last_idx` = 2**IDX_BITS-1: `idx` never exceeds it; no arithmetic wrap of the counter occurs.
- Dwell/blank counting uses one shared down-counter sized $clog2(max(DWELL_CYCLES, BLANK_CYCLES)+1).
- Step period is BLANK_CYCLES + DWELL_CYCLES. A frame is (last+1) × period cycles from the first BLANK/DWELL cycle.
- Reset mid-scan: immediate return to reset values; `en` deasserts asynchronously.

Decomposition:
- Package `scan_pkg`:
  - `scan_state_t` enum (IDLE, BLANK, DWELL).
  - Timer width function.
- Sub-module `scan_timer`:
  - Loadable down-counter.
  - Ports: clk, rst_n, load, load_val, expired.
  - Used for both BLANK and DWELL intervals.
- FSM, index counter and output registers live in `scan_sequencer`.

Test Plan:
- Reset + continuous frame: DWELL=4, BLANK=2, last=15, one_shot=0, start pulse.
  - `en` first rises 3 cycles after start; `idx` 0..15 each held 4 cycles with `en` high and 2 low between.
  - `frame_done` after 96 cycles; `idx` wraps to 0 and the scan continues.
- One-shot, last=3:
  - Exactly 4 `step` pulses, one `frame_done`.
  - Then `busy` = 0, `en` = 0, `idx` = 3; no further activity for 50 cycles.
- Stop mid-dwell at `idx` = 5:
  - Next cycle `en` = 0, `busy` = 0, `idx` = 5; no `frame_done`.
  - A new start restarts at `idx` = 0.
- Simultaneous `start` + `stop` in IDLE:
  - Stays IDLE.
- `start` while busy with last=15, then different last=2:
  - The second start has no effect; the frame still ends at 15.
- BLANK_CYCLES = 0, last=0:
  - `en` stays high continuously in continuous mode.
  - `frame_done` every DWELL cycles; `idx` stays 0.
- Async reset asserted mid-DWELL:
  - `en`, `busy`, `idx` go to 0 without waiting for a clock edge.
